// File: rtl/sr_cmd_conditioner.sv
// Conditions raw set/reset switch levels into clean, spaced, mutually exclusive
// one-cycle s/r pulses for a downstream SR flip-flop.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a debounced rising request
// PULSE   | driving s or r for exactly one cycle
// HOLDOFF | enforced idle gap; new requests are parked in pending
module sr_cmd_conditioner #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_btn,
    input  logic       reset_btn,
    output logic       s,
    output logic       r,
    output logic       conflict,
    output logic       busy,
    output logic [7:0] event_cnt
);

    localparam logic [7:0] DB_LAST   = 8'(DB_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // index 0 = set channel, index 1 = reset channel
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] stable_q;
    logic [7:0] db_cnt [2];

    logic [1:0] rise;
    logic       set_ev;
    logic       rst_ev;
    logic       both_ev;

    state_t     state;
    logic [7:0] hold_cnt;
    logic       pend_vld;
    logic       pend_set;
    logic       eff_vld;
    logic       eff_set;

    assign raw = {reset_btn, set_btn};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise    = stable & ~stable_q;
    assign set_ev  = rise[0];
    assign rst_ev  = rise[1];
    assign both_ev = set_ev & rst_ev;

    // Request as it stands after this cycle's events; a fresh event overrides
    // the parked one and a simultaneous pair cancels everything.
    always_comb begin
        eff_vld = pend_vld;
        eff_set = pend_set;
        if (both_ev) begin
            eff_vld = 1'b0;
            eff_set = 1'b0;
        end else if (set_ev) begin
            eff_vld = 1'b1;
            eff_set = 1'b1;
        end else if (rst_ev) begin
            eff_vld = 1'b1;
            eff_set = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= 1'b0;
            r         <= 1'b0;
            conflict  <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            pend_vld  <= 1'b0;
            pend_set  <= 1'b0;
            event_cnt <= '0;
        end else begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= both_ev;
            if (s || r) begin
                event_cnt <= event_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    pend_vld <= 1'b0;
                    if (!both_ev && (set_ev || rst_ev)) begin
                        state <= PULSE;
                        s     <= set_ev;
                        r     <= rst_ev;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                PULSE: begin
                    state    <= HOLDOFF;
                    hold_cnt <= HOLD_LAST;
                    busy     <= 1'b1;
                    pend_vld <= eff_vld;
                    pend_set <= eff_set;
                end

                HOLDOFF: begin
                    if (hold_cnt == 8'd0) begin
                        pend_vld <= 1'b0;
                        if (eff_vld) begin
                            state <= PULSE;
                            s     <= eff_set;
                            r     <= ~eff_set;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                        pend_vld <= eff_vld;
                        pend_set <= eff_set;
                        busy     <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    pend_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner (DB_CYCLES=4, HOLD_CYCLES=2):
// latency, glitch rejection, conflict, back-to-back requests, reset abort, wrap.
module tb_sr_cmd_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_btn;
    logic       reset_btn;
    logic       s;
    logic       r;
    logic       conflict;
    logic       busy;
    logic [7:0] event_cnt;

    int total = 0;
    int bad   = 0;

    int n_s = 0, n_r = 0, n_conf = 0, n_busy = 0, n_overlap = 0;
    int b_s, b_r, b_conf, b_busy;

    sr_cmd_conditioner #(.DB_CYCLES(4), .HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_btn   (set_btn),
        .reset_btn (reset_btn),
        .s         (s),
        .r         (r),
        .conflict  (conflict),
        .busy      (busy),
        .event_cnt (event_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_s       += int'(s);
        n_r       += int'(r);
        n_conf    += int'(conflict);
        n_busy    += int'(busy);
        n_overlap += int'(s & r);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_s    = n_s;
        b_r    = n_r;
        b_conf = n_conf;
        b_busy = n_busy;
    endtask

    task automatic press(input bit which);
        @(negedge clk);
        if (which) reset_btn = 1'b1;
        else       set_btn   = 1'b1;
        repeat (10) @(negedge clk);
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", event_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single set request: s exactly one cycle, six edges after first sample
        snap();
        set_btn = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("lat_s_early", s, 0);
        @(posedge clk);
        #1;
        chk("lat_s", s, 1);
        chk("lat_r", r, 0);
        chk("lat_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("lat_s_end", s, 0);
        chk("lat_cnt", event_cnt, 1);
        repeat (6) @(negedge clk);
        chk("lat_busy_cycles", n_busy - b_busy, 3);
        chk("lat_s_count", n_s - b_s, 1);
        set_btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("fall_no_pulse", n_s - b_s, 1);

        // 3-cycle glitch is rejected
        snap();
        set_btn = 1'b1;
        repeat (3) @(negedge clk);
        set_btn = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch_s", n_s - b_s, 0);
        chk("glitch_cnt", event_cnt, 1);

        // simultaneous requests
        snap();
        set_btn   = 1'b1;
        reset_btn = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("conf_flag", conflict, 1);
        repeat (8) @(negedge clk);
        chk("conf_count", n_conf - b_conf, 1);
        chk("conf_sr", (n_s - b_s) + (n_r - b_r), 0);
        chk("conf_busy", n_busy - b_busy, 0);
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (12) @(negedge clk);

        // reset request one cycle after set: s, two holdoff cycles, then r
        snap();
        set_btn = 1'b1;
        @(negedge clk);
        reset_btn = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("b2b_s", s, 1);
        @(posedge clk);
        #1 chk("b2b_gap1", {s, r, busy}, 3'b001);
        @(posedge clk);
        #1 chk("b2b_gap2", {s, r, busy}, 3'b001);
        @(posedge clk);
        #1 chk("b2b_r", {s, r}, 2'b01);
        @(posedge clk);
        #1 chk("b2b_cnt", event_cnt, 3);
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (15) @(negedge clk);
        chk("b2b_overlap", n_overlap, 0);

        // reset during holdoff with a parked reset request
        snap();
        set_btn = 1'b1;
        @(negedge clk);
        reset_btn = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        @(posedge clk);
        #1 chk("abort_outs", {s, r, conflict, busy}, 4'b0000);
        chk("abort_cnt", event_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_r", n_r - b_r, 0);

        // input held high through reset release yields one event
        snap();
        rst     = 1'b1;
        set_btn = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_s", n_s - b_s, 1);
        chk("held_cnt", event_cnt, 1);
        set_btn = 1'b0;
        repeat (12) @(negedge clk);

        // 256 alternating events wrap the counter
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        snap();
        for (int i = 0; i < 256; i++) begin
            press(i[0]);
            if (i == 254) chk("wrap_255", event_cnt, 255);
        end
        chk("wrap_0", event_cnt, 0);
        chk("wrap_s", n_s - b_s, 128);
        chk("wrap_r", n_r - b_r, 128);
        chk("overlap", n_overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
